// File: rtl/fpu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fpu_pkg : shared op codes, qNaN constant and dispatcher FSM states |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package fpu_pkg;

  localparam logic [1:0]  OP_ADD   = 2'b00;
  localparam logic [1:0]  OP_MUL   = 2'b10;
  localparam logic [31:0] FPU_QNAN = 32'h7FC0_0000;

  // {A, B, op} as stored in the command FIFO
  localparam int CMD_W = 66;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/fpu_cmd_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fpu_cmd_fifo : synchronous command FIFO with full/empty flags      |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fpu_cmd_fifo #(
  parameter int WIDTH = 66,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;

  // Extra pointer MSB tells full from empty when the indices match
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (push && !full)
        r_wptr <= r_wptr + (AW+1)'(1);
      if (pop && !empty)
        r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      r_mem[r_wptr[AW-1:0]] <= wdata;
  end

  assign rdata = r_mem[r_rptr[AW-1:0]];
  assign empty = (r_wptr == r_rptr);
  assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

endmodule
`default_nettype wire

// File: rtl/fpu_dispatcher.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fpu_dispatcher : queues {A,B,op} commands, issues them to the fpu  |
// | one at a time, returns {R,op}. FPU_TIMEOUT_EN adds a WAIT timeout. |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fpu_dispatcher
  import fpu_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic [1:0]  cmd_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_r,
  output logic [1:0]  rsp_op,
  output logic        rsp_timeout,
  output logic        busy,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  output logic [1:0]  fpu_op,
  output logic        fpu_start,
  input  logic [31:0] fpu_r,
  input  logic        fpu_done
);

  state_t           r_state;
  logic [31:0]      r_fpu_a;
  logic [31:0]      r_fpu_b;
  logic [1:0]       r_fpu_op;
  logic             r_fpu_start;
  logic [31:0]      r_rsp_r;
  logic [1:0]       r_rsp_op;
  logic             r_rsp_valid;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_expire;
  logic [CMD_W-1:0] w_head;

  assign w_push = cmd_valid && !w_full;
  assign w_pop  = (r_state == ST_IDLE) && !w_empty;

  fpu_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .wdata ({cmd_a, cmd_b, cmd_op}),
    .pop   (w_pop),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

`ifdef FPU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_wait_cnt;
  logic          r_rsp_timeout;

  assign w_expire = (r_state == ST_WAIT) && (r_wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  // ISSUE always precedes WAIT, so clearing there restarts every wait at zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait_cnt    <= '0;
      r_rsp_timeout <= 1'b0;
    end else begin
      if (r_state == ST_ISSUE)
        r_wait_cnt <= '0;
      else if (r_state == ST_WAIT)
        r_wait_cnt <= r_wait_cnt + CW'(1);
      if (r_state == ST_WAIT) begin
        if (fpu_done)
          r_rsp_timeout <= 1'b0;
        else if (w_expire)
          r_rsp_timeout <= 1'b1;
      end
    end
  end

  assign rsp_timeout = r_rsp_timeout;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYCLES != 0);
  assign w_expire     = 1'b0;
  assign rsp_timeout  = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_fpu_a     <= '0;
      r_fpu_b     <= '0;
      r_fpu_op    <= '0;
      r_fpu_start <= 1'b0;
      r_rsp_r     <= '0;
      r_rsp_op    <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_fpu_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_fpu_a     <= w_head[65:34];
            r_fpu_b     <= w_head[33:2];
            r_fpu_op    <= w_head[1:0];
            r_fpu_start <= 1'b1;
            r_state     <= ST_ISSUE;
          end
        end
        // done may still be high from the previous op; it is not looked at here
        ST_ISSUE: r_state <= ST_WAIT;
        ST_WAIT: begin
          if (fpu_done) begin
            r_rsp_r     <= fpu_r;
            r_rsp_op    <= r_fpu_op;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_HOLD;
          end else if (w_expire) begin
            r_rsp_r     <= FPU_QNAN;
            r_rsp_op    <= r_fpu_op;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = !w_full;
  assign busy      = (r_state != ST_IDLE) || !w_empty;
  assign rsp_valid = r_rsp_valid;
  assign rsp_r     = r_rsp_r;
  assign rsp_op    = r_rsp_op;
  assign fpu_a     = r_fpu_a;
  assign fpu_b     = r_fpu_b;
  assign fpu_op    = r_fpu_op;
  assign fpu_start = r_fpu_start;

endmodule
`default_nettype wire
